// File: rtl/eco32f_ctrl_exc_pkg.sv
// eco32f_pkg: PSW bit positions, exception cause codes and controller FSM states
package eco32f_pkg;
  localparam int PSW_V = 27;
  localparam int PSW_UC = 26;
  localparam int PSW_UP = 25;
  localparam int PSW_UO = 24;
  localparam int PSW_IC = 23;
  localparam int PSW_IP = 22;
  localparam int PSW_IO = 21;
  localparam int PSW_PRI_HI = 20;
  localparam int PSW_PRI_LO = 16;
  localparam logic [4:0] EXC_BUS = 5'd16;
  localparam logic [4:0] EXC_ILL = 5'd17;
  localparam logic [4:0] EXC_PRIV = 5'd18;
  localparam logic [4:0] EXC_TRAP = 5'd20;
  typedef enum logic {ST_RUN, ST_FLUSH} state_t;
endpackage

// File: rtl/eco32f_ctrl_exc_if.sv
// eco32f_ctrl_exc_if: pipeline-side signals of the exception-aware controller
interface eco32f_ctrl_exc_if #(parameter int NUM_IRQ = 16);
  logic if_stall, id_stall, ex_stall, mem_stall;
  logic if_flush, id_flush, ex_flush, mem_flush;
  logic id_bubble, lsu_stall;
  logic [31:0] ex_rf_x, ex_branch_imm;
  logic ex_op_rrb, ex_op_j, ex_op_jr, ex_cond_true;
  logic do_branch;
  logic [31:0] branch_pc;
  logic mem_valid;
  logic [31:0] mem_pc;
  logic mem_exc_ibus_fault, mem_exc_illegal, mem_exc_priv, mem_exc_trap, mem_exc_dbus_fault;
  logic mem_op_rfx, psw_we;
  logic [31:0] psw_wdata;
  logic [NUM_IRQ-1:0] irq;
  logic [31:0] psw;
  logic epc_we;
  logic [31:0] epc;
  logic do_exception;
  logic [31:0] exception_pc;
  modport master (
    output if_stall, id_stall, ex_stall, mem_stall, if_flush, id_flush, ex_flush, mem_flush,
    output do_branch, branch_pc, psw, epc_we, epc, do_exception, exception_pc,
    input id_bubble, lsu_stall, ex_rf_x, ex_branch_imm, ex_op_rrb, ex_op_j, ex_op_jr, ex_cond_true,
    input mem_valid, mem_pc, mem_exc_ibus_fault, mem_exc_illegal, mem_exc_priv, mem_exc_trap,
    input mem_exc_dbus_fault, mem_op_rfx, psw_we, psw_wdata, irq
  );
  modport slave (
    input if_stall, id_stall, ex_stall, mem_stall, if_flush, id_flush, ex_flush, mem_flush,
    input do_branch, branch_pc, psw, epc_we, epc, do_exception, exception_pc,
    output id_bubble, lsu_stall, ex_rf_x, ex_branch_imm, ex_op_rrb, ex_op_j, ex_op_jr, ex_cond_true,
    output mem_valid, mem_pc, mem_exc_ibus_fault, mem_exc_illegal, mem_exc_priv, mem_exc_trap,
    output mem_exc_dbus_fault, mem_op_rfx, psw_we, psw_wdata, irq
  );
endinterface

// File: rtl/eco32f_ctrl_exc_irq_prio.sv
// eco32f_irq_prio: masked interrupt priority encoder, highest-numbered pending line wins
module eco32f_irq_prio #(parameter int NUM_IRQ = 16) (
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] mask,
  input  logic               en,
  output logic               pend,
  output logic [4:0]         cause
);
  logic [NUM_IRQ-1:0] m;
  assign m = irq & mask;
  assign pend = en & |m;
  always_comb begin
    cause = '0;
    for (int i = 0; i < NUM_IRQ; i++) cause = m[i] ? 5'(i) : cause;
  end
endmodule

// File: rtl/eco32f_ctrl_exc.sv
// eco32f_ctrl_exc: stall/flush/branch control with precise exception, IRQ and RFX handling at MEM
module eco32f_ctrl_exc
  import eco32f_pkg::*;
#(
  parameter int          NUM_IRQ   = 16,
  parameter logic [31:0] VEC_V0    = 32'hE000_0004,
  parameter logic [31:0] VEC_V1    = 32'hC000_0004,
  parameter logic [31:0] PSW_RESET = 32'h0
) (
  input logic clk,
  input logic rst,
  eco32f_ctrl_exc_if.master bus
);
  state_t state, state_n;
  logic [31:0] psw_q, psw_n;
  logic irq_pend, sync_exc, exc_take, rfx_take, flush_all, plus4;
  logic [4:0] irq_cause, cause;
  eco32f_irq_prio #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .irq(bus.irq), .mask(psw_q[NUM_IRQ-1:0]), .en(psw_q[PSW_IC]), .pend(irq_pend), .cause(irq_cause)
  );
  assign sync_exc = bus.mem_exc_ibus_fault | bus.mem_exc_illegal | bus.mem_exc_priv |
                    bus.mem_exc_trap | bus.mem_exc_dbus_fault;
  // Redirects are gated by rst so nothing leaks out while the core is held in reset
  assign exc_take = ~rst & bus.mem_valid & ~bus.lsu_stall & (state == ST_RUN) & (sync_exc | irq_pend);
  assign rfx_take = ~rst & bus.mem_valid & bus.mem_op_rfx & ~bus.lsu_stall & (state == ST_RUN) & ~exc_take;
  assign flush_all = (state == ST_FLUSH) | exc_take | rfx_take;
  assign cause = bus.mem_exc_ibus_fault ? EXC_BUS :
                 bus.mem_exc_illegal    ? EXC_ILL :
                 bus.mem_exc_priv       ? EXC_PRIV :
                 bus.mem_exc_trap       ? EXC_TRAP :
                 bus.mem_exc_dbus_fault ? EXC_BUS : irq_cause;
  // Trap and interrupts resume after the faulting instruction; other causes re-execute it
  assign plus4 = ~(bus.mem_exc_ibus_fault | bus.mem_exc_illegal | bus.mem_exc_priv) &
                 (bus.mem_exc_trap | ~bus.mem_exc_dbus_fault);
  always_comb begin
    state_n = (exc_take | rfx_take) ? ST_FLUSH : ST_RUN;
    psw_n = bus.psw_we ? bus.psw_wdata : psw_q;
    if (exc_take) begin
      psw_n = psw_q;
      psw_n[PSW_UC:PSW_UO] = {1'b0, psw_q[PSW_UC:PSW_UP]};
      psw_n[PSW_IC:PSW_IO] = {1'b0, psw_q[PSW_IC:PSW_IP]};
      psw_n[PSW_PRI_HI:PSW_PRI_LO] = cause;
    end else if (rfx_take) begin
      psw_n = psw_q;
      psw_n[PSW_UC:PSW_UO] = {psw_q[PSW_UP:PSW_UO], psw_q[PSW_UO]};
      psw_n[PSW_IC:PSW_IO] = {psw_q[PSW_IP:PSW_IO], psw_q[PSW_IO]};
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      psw_q <= PSW_RESET;
    end else begin
      state <= state_n;
      psw_q <= psw_n;
    end
  end
  assign bus.mem_stall = bus.lsu_stall;
  assign bus.ex_stall = bus.lsu_stall;
  assign bus.id_stall = bus.lsu_stall;
  assign bus.if_stall = (state == ST_FLUSH) ? 1'b0 : bus.lsu_stall | bus.id_bubble;
  assign bus.if_flush = flush_all;
  assign bus.id_flush = flush_all;
  assign bus.ex_flush = flush_all;
  assign bus.mem_flush = flush_all;
  assign bus.do_branch = (bus.ex_op_j | bus.ex_op_jr | (bus.ex_op_rrb & bus.ex_cond_true)) & ~exc_take;
  assign bus.branch_pc = bus.ex_op_jr ? bus.ex_rf_x : bus.ex_branch_imm;
  assign bus.psw = psw_q;
  assign bus.epc_we = exc_take;
  assign bus.epc = plus4 ? bus.mem_pc + 32'd4 : bus.mem_pc;
  assign bus.do_exception = exc_take | rfx_take;
  assign bus.exception_pc = exc_take ? (psw_q[PSW_V] ? VEC_V1 : VEC_V0) : bus.mem_pc;
endmodule
